sort_host: RTL and testbench

SORT_HOST -- requirements
Module: sort_host

---
 rtl/sort_host.sv | 244 ++++++++++++++++++++++++
 tb/tb_sort_host.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_host.sv
// Batch front-end for a toggle-command sorter: collects up to 255 words, has the
// sorter order them, then streams them back out in pop (descending) order.
module sort_host #(
    parameter int TMO = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err_ovf,
    output logic        err_tmo,
    output logic        s_clear,
    output logic        s_push,
    output logic        s_pop,
    output logic        s_sort,
    output logic [15:0] s_din,
    input  logic [15:0] s_dout,
    input  logic        s_idle,
    input  logic        s_full,
    input  logic        s_empty
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PUSH_W = 3'd3,
        ST_SORT_W = 3'd4,
        ST_POP_W  = 3'd5,
        ST_OUT    = 3'd6
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    state_t      state_r;
    state_t      state_s;
    logic        phase_r;
    logic [15:0] tmr_r;
    logic [7:0]  cnt_r;
    logic [7:0]  rem_r;
    logic        last_r;
    logic [15:0] s_din_r;
    logic [15:0] out_data_r;
    logic        clr_t_r;
    logic        push_t_r;
    logic        sort_t_r;
    logic        pop_t_r;
    logic        err_ovf_r;
    logic        err_tmo_r;

    logic        wait_st_s;
    logic        ack_s;
    logic        done_s;
    logic        tmo_s;
    logic        acc_s;
    logic        pop_s;
    logic        start_s;
    logic        issue_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        out_last_s;
    logic        busy_s;

    // Occupancy flags are informational only; the pop count comes from cnt_r.
    logic        sorter_sts_unused_s;
    assign sorter_sts_unused_s = s_full | s_empty;

    // Command-wait decode: phase 0 waits for idle to drop, phase 1 for it to rise.
    always_comb begin
        wait_st_s = (state_r == ST_CLR) || (state_r == ST_PUSH_W) ||
                    (state_r == ST_SORT_W) || (state_r == ST_POP_W);
        ack_s     = wait_st_s && !phase_r && !s_idle;
        done_s    = wait_st_s && phase_r && s_idle;
        tmo_s     = wait_st_s && !phase_r && s_idle && (tmr_r == TMO_LAST);
        acc_s     = in_ready_s && in_valid;
        pop_s     = out_valid_s && out_ready;
        start_s   = (state_r == ST_IDLE) && in_valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else if (enable) begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_s = ST_CLR;
                else          state_s = ST_IDLE;
            end
            ST_CLR: begin
                if (tmo_s)       state_s = ST_IDLE;
                else if (done_s) state_s = ST_LOAD;
                else             state_s = ST_CLR;
            end
            ST_LOAD: begin
                if (acc_s) state_s = ST_PUSH_W;
                else       state_s = ST_LOAD;
            end
            ST_PUSH_W: begin
                if (tmo_s)       state_s = ST_IDLE;
                else if (done_s) state_s = last_r ? ST_SORT_W : ST_LOAD;
                else             state_s = ST_PUSH_W;
            end
            ST_SORT_W: begin
                if (tmo_s)       state_s = ST_IDLE;
                else if (done_s) state_s = ST_POP_W;
                else             state_s = ST_SORT_W;
            end
            ST_POP_W: begin
                if (tmo_s)       state_s = ST_IDLE;
                else if (done_s) state_s = ST_OUT;
                else             state_s = ST_POP_W;
            end
            ST_OUT: begin
                if (pop_s) state_s = (rem_r == 8'd1) ? ST_IDLE : ST_POP_W;
                else       state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode; handshakes are masked while frozen so no word is taken twice or lost.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        busy_s      = (state_r != ST_IDLE);
        case (state_r)
            ST_LOAD: in_ready_s = enable;
            ST_OUT: begin
                out_valid_s = enable;
                out_last_s  = (rem_r == 8'd1);
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
        // Every entry into a wait state is a fresh command.
        issue_s = (state_s != state_r) &&
                  ((state_s == ST_CLR) || (state_s == ST_PUSH_W) ||
                   (state_s == ST_SORT_W) || (state_s == ST_POP_W));
    end

    // Command wait phase and phase-0 timeout timer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_r <= 1'b0;
            tmr_r   <= 16'd0;
        end else if (enable) begin
            if (issue_s) begin
                phase_r <= 1'b0;
                tmr_r   <= 16'd0;
            end else if (ack_s) begin
                phase_r <= 1'b1;
            end else if (wait_st_s && !phase_r) begin
                tmr_r <= tmr_r + 16'd1;
            end
        end
    end

    // Command toggles; the transitions are mutually exclusive so at most one flips per edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clr_t_r  <= 1'b0;
            push_t_r <= 1'b0;
            sort_t_r <= 1'b0;
            pop_t_r  <= 1'b0;
        end else if (enable) begin
            if ((state_r == ST_IDLE) && (state_s == ST_CLR))
                clr_t_r <= ~clr_t_r;
            if ((state_r == ST_LOAD) && (state_s == ST_PUSH_W))
                push_t_r <= ~push_t_r;
            if ((state_r == ST_PUSH_W) && (state_s == ST_SORT_W))
                sort_t_r <= ~sort_t_r;
            if (((state_r == ST_SORT_W) || (state_r == ST_OUT)) && (state_s == ST_POP_W))
                pop_t_r <= ~pop_t_r;
        end
    end

    // Batch bookkeeping, data capture and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r      <= 8'd0;
            rem_r      <= 8'd0;
            last_r     <= 1'b0;
            s_din_r    <= 16'd0;
            out_data_r <= 16'd0;
            err_ovf_r  <= 1'b0;
            err_tmo_r  <= 1'b0;
        end else if (enable) begin
            if (start_s) begin
                cnt_r     <= 8'd0;
                last_r    <= 1'b0;
                err_ovf_r <= 1'b0;
                err_tmo_r <= 1'b0;
            end
            if (acc_s) begin
                s_din_r <= in_data;
                cnt_r   <= cnt_r + 8'd1;
                last_r  <= in_last || (cnt_r == 8'd254);
                if (!in_last && (cnt_r == 8'd254))
                    err_ovf_r <= 1'b1;
            end
            if (tmo_s)
                err_tmo_r <= 1'b1;
            if (done_s && (state_r == ST_SORT_W))
                rem_r <= cnt_r;
            if (pop_s)
                rem_r <= rem_r - 8'd1;
            if (done_s && (state_r == ST_POP_W))
                out_data_r <= s_dout;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_last  = out_last_s;
    assign busy      = busy_s;
    assign out_data  = out_data_r;
    assign s_din     = s_din_r;
    assign s_clear   = clr_t_r;
    assign s_push    = push_t_r;
    assign s_sort    = sort_t_r;
    assign s_pop     = pop_t_r;
    assign err_ovf   = err_ovf_r;
    assign err_tmo   = err_tmo_r;

endmodule

// File: tb/tb_sort_host.sv
// Scoreboard bench for sort_host, driving a behavioural toggle-command sorter.
module tb_sort_host;

    localparam int TMO = 4;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err_ovf;
    logic        err_tmo;
    logic        s_clear;
    logic        s_push;
    logic        s_pop;
    logic        s_sort;
    logic [15:0] s_din;
    logic [15:0] s_dout;
    logic        s_idle;
    logic        s_full;
    logic        s_empty;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int n_clr = 0;
    int n_push = 0;
    int n_sort = 0;
    int n_pop = 0;
    int b_clr, b_push, b_sort, b_pop;

    logic [16:0] exp_q[$];
    logic [15:0] sq[$];
    logic        stuck;

    sort_host #(.TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_ovf(err_ovf), .err_tmo(err_tmo),
        .s_clear(s_clear), .s_push(s_push), .s_pop(s_pop), .s_sort(s_sort),
        .s_din(s_din), .s_dout(s_dout), .s_idle(s_idle), .s_full(s_full), .s_empty(s_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural sorter: a command is seen one edge after its toggle, executed the next.
    logic [3:0] m_prev, m_cmd, tcur, tprev, tdiff;
    assign tcur    = {s_clear, s_push, s_sort, s_pop};
    assign tdiff   = tcur ^ tprev;
    assign s_full  = 1'b0;
    assign s_empty = 1'b0;

    task automatic m_exec(input logic [3:0] cmd);
        int i;
        if (cmd[3]) sq.delete();
        if (cmd[2]) begin
            i = 0;
            while (i < sq.size() && sq[i] >= s_din) i++;
            sq.insert(i, s_din);
        end
        if (cmd[0] && sq.size() > 0) s_dout <= sq.pop_front();
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_prev <= 4'b0;
            m_cmd  <= 4'b0;
            s_idle <= 1'b1;
            s_dout <= 16'h0;
            sq.delete();
        end else if (stuck) begin
            m_prev <= tcur;
            s_idle <= 1'b1;
        end else if (s_idle) begin
            if (tcur != m_prev) begin
                m_cmd  <= tcur ^ m_prev;
                m_prev <= tcur;
                s_idle <= 1'b0;
            end
        end else begin
            m_exec(m_cmd);
            s_idle <= 1'b1;
        end
    end

    // Toggle counter; also flags any cycle where two commands flip together.
    task automatic tog_note();
        n_clr  <= n_clr + int'(tdiff[3]);
        n_push <= n_push + int'(tdiff[2]);
        n_sort <= n_sort + int'(tdiff[1]);
        n_pop  <= n_pop + int'(tdiff[0]);
        check("single_toggle", $countones(tdiff), 1);
    endtask

    always @(negedge clk) begin
        if (!rstn) tprev <= 4'b0;
        else begin
            if (tdiff != 4'b0) tog_note();
            tprev <= tcur;
        end
    end

    // Scoreboard monitor: compares each accepted output word against the queue head.
    task automatic sb_compare();
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_out", {15'd0, out_last, out_data}, 32'h1ffff);
        end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, {16'd0, e[15:0]});
            check("out_last", out_last, {31'd0, e[16]});
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            sb_compare();
            n_out <= n_out + 1;
        end
    end

    task automatic push_word(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("in_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, (t < 20000), 1);
    endtask

    task automatic snap();
        b_clr = n_clr; b_push = n_push; b_sort = n_sort; b_pop = n_pop;
    endtask

    task automatic check_cnt(input string name, input int c, input int p, input int s, input int o);
        check({name, "_clr"}, n_clr - b_clr, c);
        check({name, "_push"}, n_push - b_push, p);
        check({name, "_sort"}, n_sort - b_sort, s);
        check({name, "_pop"}, n_pop - b_pop, o);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_last"}, out_last, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_errs"}, {err_ovf, err_tmo}, 0);
        check({name, "_toggles"}, tcur, 0);
        check({name, "_s_din"}, s_din, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ob;
        logic ok;
        logic [15:0] d0;
        rstn = 1'b0; enable = 1'b1; stuck = 1'b0;
        in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // Three-word batch comes back descending.
        snap();
        exp_q.push_back({1'b0, 16'h0003});
        exp_q.push_back({1'b0, 16'h0002});
        exp_q.push_back({1'b1, 16'h0001});
        push_word(16'h0003, 1'b0);
        push_word(16'h0001, 1'b0);
        push_word(16'h0002, 1'b1);
        wait_idle("b3");
        check_cnt("b3", 1, 3, 1, 3);
        check("b3_errs", {err_ovf, err_tmo}, 0);

        // Single word.
        snap();
        exp_q.push_back({1'b1, 16'h00AA});
        push_word(16'h00AA, 1'b1);
        wait_idle("b1");
        check_cnt("b1", 1, 1, 1, 1);

        // Output stall: word held, no pop command issued.
        snap();
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h0009});
        exp_q.push_back({1'b1, 16'h0005});
        push_word(16'h0005, 1'b0);
        push_word(16'h0009, 1'b1);
        t = 0;
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("stall_seen", out_valid, 1);
        d0 = out_data;
        ob = n_pop;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_data !== d0 || !out_valid || out_last) ok = 1'b0;
        end
        check("stall_stable", ok, 1);
        check("stall_data", d0, 16'h0009);
        check("stall_pops", n_pop - ob, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle("stall");
        check_cnt("stall", 1, 2, 1, 2);

        // Overflow: 255 words accepted, the 256th refused.
        snap();
        for (int k = 254; k >= 0; k--) exp_q.push_back({(k == 0), 16'(k)});
        ob = n_out;
        for (int k = 0; k < 255; k++) push_word(16'(k), 1'b0);
        check("ovf_flag", err_ovf, 1);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) ok = 1'b0;
        end
        check("ovf_refuse", ok, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle("ovf");
        check("ovf_outs", n_out - ob, 255);
        check("ovf_sticky", err_ovf, 1);
        check_cnt("ovf", 1, 255, 1, 255);

        // Stuck sorter: clear never acknowledged.
        snap();
        stuck = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_last = 1'b1; in_data = 16'h1234;
        #1 check("tmo_idle_ready", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("tmo_early", {busy, err_tmo}, 2'b10);
        end
        @(posedge clk);
        @(negedge clk);
        check("tmo_flag", err_tmo, 1);
        check("tmo_busy", busy, 0);
        check("tmo_ovf_cleared", err_ovf, 0);
        check_cnt("tmo", 1, 0, 0, 0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the second pop wait, then a clean batch.
        snap();
        exp_q.push_back({1'b0, 16'h0007});
        exp_q.push_back({1'b0, 16'h0006});
        exp_q.push_back({1'b1, 16'h0004});
        push_word(16'h0007, 1'b0);
        push_word(16'h0004, 1'b0);
        push_word(16'h0006, 1'b1);
        t = 0;
        while (n_pop - b_pop < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("por_popw", {busy, out_valid, out_data}, {2'b10, 16'h0007});
        #2 rstn = 1'b0;
        #1 check_reset_outs("por");
        exp_q.delete();
        repeat (2) @(negedge clk);
        snap();
        @(posedge clk); #1 rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_cnt("por_quiet", 0, 0, 0, 0);
        exp_q.push_back({1'b0, 16'h0030});
        exp_q.push_back({1'b0, 16'h0020});
        exp_q.push_back({1'b1, 16'h0010});
        push_word(16'h0010, 1'b0);
        push_word(16'h0030, 1'b0);
        push_word(16'h0020, 1'b1);
        wait_idle("after_por");
        check_cnt("after_por", 1, 3, 1, 3);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
